etapa1_bram_loader: RTL and testbench
=====================================

Name: etapa1_bram_loader

Overview:
- Front-end stage directly upstream of etapa2.
- Accepts a stream of 16-bit signed samples over a valid/ready handshake and forms 17-bit pairwise sums.
- Writes one frame of N_WORDS sums into the 17-bit x 256 BRAMB port A, then pulses data_done.
- Holds off the next frame until etapa2 has acknowledged with busy high and then released it with busy low.

Parameters:
- N_WORDS, 144, words per frame; legal range 1..256.
- ADDR_W, 8, BRAM address width.
- IN_W, 16, input sample width, signed.
- OUT_W, 17, BRAM data width; must equal IN_W+1.

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- s_valid  input  1  input sample valid.
- s_data  input  IN_W  signed input sample.
- s_ready  output  1  stage can accept a sample this cycle.
- busy  input  1  etapa2 processing flag; acknowledges data_done.
- wea  output  1  BRAM port A write enable.
- addra  output  ADDR_W  BRAM port A address.
- dina  output  OUT_W  BRAM port A write data.
- data_done  output  1  one-cycle pulse: frame fully written.
- frame_cnt  output  8  completed frames, wraps 255->0.

Behaviour:
- Reset (reset=0, asynchronous assert, synchronous release):
  - state=IDLE.
  - s_ready=0, wea=0, addra=0, dina=0, data_done=0, frame_cnt=0.
  - Internal prev_sample=0, word counter=0.
- State machine (four states):
  - IDLE: s_ready=0. Go to FILL when busy=0. If busy=1, stay in IDLE.
  - FILL: s_ready=1. Each cycle with s_valid&&s_ready is an accepted sample.
  - DONE_ACK: entered the cycle after the last write. data_done=1 for exactly this first cycle. Stay until busy=1, then go to DRAIN.
  - DRAIN: stay while busy=1. When busy=0, go to IDLE, then FILL on the next cycle.
- Per accepted sample:
  - dina <= sign_ext(s_data) + sign_ext(prev_sample), 17-bit signed. Cannot overflow.
  - prev_sample <= s_data.
  - addra <= word counter; wea <= 1; word counter increments.
  - Latency: sample accepted at edge k -> wea=1 with addra/dina valid during cycle k+1.
- No accepted sample -> wea=0. addra/dina hold their last values.
- Frame start: first sample pairs with 0 (prev_sample cleared on entering FILL). Output is therefore sign_ext(s_data).
- Last word (counter == N_WORDS-1 accepted):
  - s_ready drops combinationally-registered on the next cycle; no sample is accepted beyond N_WORDS.
  - The word counter returns to 0.
  - Go to DONE_ACK; data_done is asserted in the cycle after the last wea.
- frame_cnt increments on the data_done cycle.
- Gaps: s_valid=0 mid-frame stalls without writes; the pairing state is kept across the gap.
- busy asserted during FILL: ignored. The frame continues; busy is only sampled in IDLE, DONE_ACK and DRAIN.
- busy already 1 on the data_done cycle: move to DRAIN on the next edge.
- Reset mid-frame: the partial frame is abandoned, no data_done, and the next frame starts at addra=0.
- addra never exceeds N_WORDS-1, so there is no wrap within the 256-deep BRAM.

Decomposition:
- Shared package etapa_pkg holds:
  - N_WORDS, ADDR_W, OUT_W constants.
  - The state enum typedef for etapa1_bram_loader, 2-bit.
  - The sample_t (signed IN_W) and bram_word_t (signed OUT_W) typedefs, shared with etapa2.
- One natural sub-module: pair_adder, a registered 17-bit sign-extending adder with a clear input.

Test Plan:
- Basic frame: hold busy=0 and stream samples 1..144 with s_valid tied high.
  - Writes: addra 0..143, dina 1,3,5,...,287, wea high for 144 consecutive cycles.
  - data_done pulses once, one cycle after the last write; frame_cnt=1.
- Signed extremes: samples -32768,-32768,32767,32767.
  - dina = -32768, -65536, -1, 65534.
  - Check the 17-bit values exactly (0x18000, 0x10000, 0x1FFFF, 0x0FFFE).
- Backpressure handshake: after data_done hold busy=0 for 5 cycles, then busy=1 for 10, then 0.
  - s_ready stays 0 until 2 cycles after busy falls.
  - The second frame restarts at addra=0 with the first dina = sign_ext of its first sample.
- Stalls: toggle s_valid randomly, roughly 50%, over a full frame.
  - Exactly 144 writes, contiguous addresses, correct pairing across gaps.
  - No write happens while s_valid=0.
- Reset mid-frame: drive reset=0 after 60 writes, release, then send a full frame.
  - All outputs are 0 during reset; no data_done for the aborted frame.
  - The new frame writes 0..143 and frame_cnt=1.
- Extra input: keep s_valid=1 after the 144th sample.
  - s_ready=0; the extra samples are not consumed; no 145th write occurs.

Source files
------------

// File: rtl/etapa_pkg.sv
// Constants and types shared between the etapa1 loader and the etapa2 consumer.
package etapa_pkg;
  localparam int N_WORDS = 144;
  localparam int ADDR_W  = 8;
  localparam int IN_W    = 16;
  localparam int OUT_W   = IN_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FILL     = 2'd1,
    ST_DONE_ACK = 2'd2,
    ST_DRAIN    = 2'd3
  } state_t;

  typedef logic signed [IN_W-1:0]  sample_t;
  typedef logic signed [OUT_W-1:0] bram_word_t;
endpackage

// File: rtl/pair_adder.sv
// Registered sign-extending sum of the current sample and the previous one.
module pair_adder
  import etapa_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [IN_W-1:0]  sample,
  output logic [OUT_W-1:0] sum
);
  sample_t prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev <= '0;
      sum  <= '0;
    end else if (clr) begin
      prev <= '0;
    end else if (en) begin
      // Both operands widen with sign before the add, so the result never overflows.
      sum  <= bram_word_t'(sample_t'(sample)) + bram_word_t'(prev);
      prev <= sample_t'(sample);
    end
  end
endmodule

// File: rtl/etapa1_bram_loader.sv
// Streams pairwise sums of input samples into BRAM port A, one frame at a time,
// and handshakes each finished frame with etapa2 via data_done/busy.
module etapa1_bram_loader
  import etapa_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  input  logic [IN_W-1:0]   s_data,
  output logic              s_ready,
  input  logic              busy,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [OUT_W-1:0]  dina,
  output logic              data_done,
  output logic [7:0]        frame_cnt
);
  state_t            state;
  logic [ADDR_W-1:0] wcnt;
  logic              last_pend;
  logic              accept;
  logic              clr;

  // last_pend covers the cycle where the final word is on the BRAM bus.
  assign s_ready = (state == ST_FILL) && !last_pend;
  assign accept  = s_valid && s_ready;
  assign clr     = (state == ST_IDLE) && !busy;

  pair_adder u_add (
    .clk    (clk),
    .reset  (reset),
    .clr    (clr),
    .en     (accept),
    .sample (s_data),
    .sum    (dina)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      wcnt      <= '0;
      last_pend <= 1'b0;
      wea       <= 1'b0;
      addra     <= '0;
      data_done <= 1'b0;
      frame_cnt <= '0;
    end else begin
      wea       <= accept;
      data_done <= 1'b0;
      if (accept) addra <= wcnt;
      case (state)
        ST_IDLE: if (!busy) state <= ST_FILL;
        ST_FILL: begin
          if (last_pend) begin
            last_pend <= 1'b0;
            data_done <= 1'b1;
            frame_cnt <= frame_cnt + 8'd1;
            state     <= ST_DONE_ACK;
          end else if (accept) begin
            if (wcnt == ADDR_W'(N_WORDS - 1)) begin
              wcnt      <= '0;
              last_pend <= 1'b1;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
        end
        ST_DONE_ACK: if (busy) state <= ST_DRAIN;
        ST_DRAIN:    if (!busy) state <= ST_IDLE;
        default:     state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_etapa1_bram_loader.sv
// Directed/random bench for etapa1_bram_loader against a frame-level reference model.
module tb_etapa1_bram_loader;
  localparam int N = 144;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_ready;
  logic        busy = 1'b0;
  logic        wea;
  logic [7:0]  addra;
  logic [16:0] dina;
  logic        data_done;
  logic [7:0]  frame_cnt;

  etapa1_bram_loader dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .busy(busy), .wea(wea), .addra(addra), .dina(dina), .data_done(data_done),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic signed [15:0] src [0:N-1];
  logic [7:0]  wr_addr [$];
  logic [16:0] wr_data [$];
  int          wr_cyc  [$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      if (wea) begin
        wr_addr.push_back(addra);
        wr_data.push_back(dina);
        wr_cyc.push_back(cyc);
      end
      if (data_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  // Offers src[0..n-1] in order; pct is the chance per cycle that s_valid is raised.
  task automatic stream(input int n, input int pct, input int extra);
    int acc = 0;
    int c = 0;
    logic v, rdy;
    while (acc < n && c < 3000) begin
      @(negedge clk);
      v = ($urandom_range(99) < pct);
      s_valid = v;
      s_data  = v ? src[acc] : 16'($urandom);
      rdy = s_ready;
      @(posedge clk);
      if (v && rdy) acc++;
      c++;
    end
    chk("stream_accepted", acc, n);
    // Keep offering after the frame is complete; none of these may be taken.
    for (int i = 0; i < extra; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = 16'h03E7;
      if (s_ready !== 1'b0) chk("extra_not_ready", s_ready, 0);
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int c = 0;
    while (done_cnt < target && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("done_seen", done_cnt, target);
  endtask

  // Expected word i of a frame: sample i plus sample i-1, with zero before the first.
  task automatic check_frame(input string tag);
    int e;
    chk({tag, "_nwrites"}, wr_data.size(), N);
    for (int i = 0; i < N && i < wr_data.size(); i++) begin
      e = int'(src[i]) + ((i > 0) ? int'(src[i-1]) : 0);
      chk($sformatf("%s_addr%0d", tag, i), wr_addr[i], i);
      chk($sformatf("%s_data%0d", tag, i), wr_data[i], e & 32'h1FFFF);
    end
  endtask

  task automatic wait_ready();
    int c = 0;
    while (s_ready !== 1'b1 && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("wait_ready", s_ready, 1);
  endtask

  initial begin
    int d0;
    // Reset state
    #2;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_wea", wea, 0);
    chk("rst_addra", addra, 0);
    chk("rst_dina", dina, 0);
    chk("rst_done", data_done, 0);
    chk("rst_fcnt", frame_cnt, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Frame 1: ramp 1..144, s_valid held high, then extra offered samples.
    for (int i = 0; i < N; i++) src[i] = 16'(i + 1);
    stream(N, 100, 10);
    wait_done(1);
    check_frame("f1");
    if (wr_cyc.size() == N) begin
      chk("f1_contig", wr_cyc[N-1] - wr_cyc[0], N - 1);
      chk("f1_done_after_last", done_cyc, wr_cyc[N-1] + 1);
    end
    chk("f1_fcnt", frame_cnt, 1);
    chk("f1_idle_ready", s_ready, 0);

    // Handshake: busy low 5, high 10, then low; ready returns 2 cycles later.
    clear_log();
    for (int i = 0; i < 5; i++) begin @(negedge clk); chk("hs_lo_ready", s_ready, 0); end
    busy = 1'b1;
    for (int i = 0; i < 10; i++) begin @(negedge clk); chk("hs_hi_ready", s_ready, 0); end
    busy = 1'b0;
    @(negedge clk);
    chk("hs_ready_1", s_ready, 0);
    @(negedge clk);
    chk("hs_ready_2", s_ready, 1);
    chk("hs_single_done", done_cnt, 1);
    chk("hs_no_writes", wr_data.size(), 0);

    // Frame 2: signed extremes lead, random remainder.
    src[0] = -16'sd32768; src[1] = -16'sd32768; src[2] = 16'sd32767; src[3] = 16'sd32767;
    for (int i = 4; i < N; i++) src[i] = 16'($urandom);
    stream(N, 100, 0);
    wait_done(2);
    check_frame("f2");
    if (wr_data.size() >= 4) begin
      chk("ext0", wr_data[0], 32'h18000);
      chk("ext1", wr_data[1], 32'h10000);
      chk("ext2", wr_data[2], 32'h1FFFF);
      chk("ext3", wr_data[3], 32'h0FFFE);
    end
    chk("f2_fcnt", frame_cnt, 2);

    // Frame 3: random stalls, busy raised during the fill (ignored there).
    clear_log();
    busy = 1'b1;
    repeat (3) @(negedge clk);
    busy = 1'b0;
    wait_ready();
    busy = 1'b1;
    for (int i = 0; i < N; i++) src[i] = 16'($urandom);
    stream(N, 50, 0);
    wait_done(3);
    check_frame("f3");
    chk("f3_fcnt", frame_cnt, 3);
    repeat (4) @(negedge clk);
    chk("f3_drain_ready", s_ready, 0);
    busy = 1'b0;

    // Frame 4: abandoned by reset after 60 writes.
    wait_ready();
    clear_log();
    for (int i = 0; i < N; i++) src[i] = 16'($urandom);
    stream(60, 100, 0);
    d0 = done_cnt;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mrst_s_ready", s_ready, 0);
    chk("mrst_wea", wea, 0);
    chk("mrst_addra", addra, 0);
    chk("mrst_dina", dina, 0);
    chk("mrst_done", data_done, 0);
    chk("mrst_fcnt", frame_cnt, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("mrst_no_done", done_cnt, d0);
    clear_log();
    for (int i = 0; i < N; i++) src[i] = 16'($urandom);
    stream(N, 70, 3);
    wait_done(d0 + 1);
    check_frame("f5");
    chk("f5_fcnt", frame_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
